pulp_sync_debounce: RTL and testbench

- Downstream stage of the 2–4 flop input synchronizer. Consumes the already-synchronized serial level in the clk_i domain.
- Rejects glitches shorter than a programmable qualification window and produces a clean debounced level.
- Generates single-cycle rise/fall pulses and keeps a saturating count of rejected glitches.
- Used behind GPIO, external-interrupt and strap inputs.

---
 rtl/pulp_sync_debounce.sv | 136 +++++++++++++
 tb/tb_pulp_sync_debounce.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulp_sync_debounce.sv
// Glitch filter for an already-synchronized serial level.
// A change on serial_i is accepted only after it has been seen on Neff
// consecutive clock edges. Accepted changes produce a one-cycle rise/fall pulse.
// Changes that revert before Neff edges are counted in a saturating glitch counter.

module pulp_sync_debounce #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned GLITCH_W  = 8,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    input  logic                serial_i,
    input  logic [CNT_W-1:0]    threshold_i,
    input  logic                clr_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                busy_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        QUALIFY  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    logic [CNT_W-1:0]    neff;
    logic [CNT_W:0]      cnt_inc;
    logic                differs;
    logic                qualified;
    logic                glitch_sat;

    // Effective threshold: a programmed zero behaves like one.
    assign neff = (threshold_i == '0) ? CNT_W'(1) : threshold_i;

    // One bit wider than the counter so the compare can never wrap, even
    // when the threshold is lowered below the running count.
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign qualified = (cnt_inc >= {1'b0, neff});
    assign differs   = (serial_i != level_q);
    assign glitch_sat = (glitch_q == {GLITCH_W{1'b1}});

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            level_q  <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    // Next-state logic: qualify changes, flag glitches, emit edge pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;

        if (!en_i) begin
            // Disabled: abandon any qualification without counting a glitch.
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                STABLE: begin
                    if (differs) begin
                        if (neff == CNT_W'(1)) begin
                            level_d = ~level_q;
                            rise_d  = ~level_q;
                            fall_d  = level_q;
                        end else begin
                            state_d = QUALIFY;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (!differs) begin
                        // Input reverted before qualifying: a glitch.
                        state_d = STABLE;
                        cnt_d   = '0;
                        if (!glitch_sat) begin
                            glitch_d = glitch_q + GLITCH_W'(1);
                        end
                    end else if (qualified) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                        level_d = ~level_q;
                        rise_d  = ~level_q;
                        fall_d  = level_q;
                    end else begin
                        // qualified==0 implies cnt_inc < neff, so this fits.
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Clear has priority over a simultaneous glitch increment.
        if (clr_i) begin
            glitch_d = '0;
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign busy_o       = (state_q == QUALIFY);
    assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_pulp_sync_debounce.sv
// Bench for pulp_sync_debounce: a run-length reference model predicts the
// outputs for each driven cycle, the prediction is queued, then popped and
// compared once the DUT has taken the edge.

module tb_pulp_sync_debounce;

    localparam int unsigned CW = 16;
    localparam int unsigned GW = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          en_i;
    logic          serial_i;
    logic [CW-1:0] threshold_i;
    logic          clr_i;
    logic          level_o;
    logic          rise_o;
    logic          fall_o;
    logic          busy_o;
    logic [GW-1:0] glitch_cnt_o;

    typedef struct packed {
        logic          level;
        logic          rise;
        logic          fall;
        logic          busy;
        logic [GW-1:0] glitch;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic m_level;
    int   m_run;
    int   m_glitch;

    // Observation tallies for directed checks.
    int n_rise, n_fall, n_busy;

    pulp_sync_debounce #(
        .CNT_W    (CW),
        .GLITCH_W (GW),
        .RESET_VAL(1'b0)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .en_i        (en_i),
        .serial_i    (serial_i),
        .threshold_i (threshold_i),
        .clr_i       (clr_i),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .busy_o      (busy_o),
        .glitch_cnt_o(glitch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level  = 1'b0;
        m_run    = 0;
        m_glitch = 0;
        exp_q.delete();
    endtask

    // Predict one edge, queue it, let the DUT take the edge, then compare.
    task automatic step();
        exp_t e;
        exp_t got;
        int   neff;
        logic m_rise, m_fall;
        neff   = (threshold_i == '0) ? 1 : int'(threshold_i);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!en_i) begin
            m_run = 0;
        end else if (serial_i != m_level) begin
            m_run++;
            if (m_run >= neff) begin
                m_level = ~m_level;
                m_rise  = m_level;
                m_fall  = ~m_level;
                m_run   = 0;
            end
        end else begin
            if (m_run > 0 && m_glitch < (1 << GW) - 1) m_glitch++;
            m_run = 0;
        end
        if (clr_i) m_glitch = 0;
        e.level  = m_level;
        e.rise   = m_rise;
        e.fall   = m_fall;
        e.busy   = (m_run > 0);
        e.glitch = GW'(m_glitch);
        exp_q.push_back(e);

        @(posedge clk_i);
        #1;
        got = exp_q.pop_front();
        check("level", 32'(level_o), 32'(got.level));
        check("rise", 32'(rise_o), 32'(got.rise));
        check("fall", 32'(fall_o), 32'(got.fall));
        check("busy", 32'(busy_o), 32'(got.busy));
        check("glitch", 32'(glitch_cnt_o), 32'(got.glitch));
        check("one_hot_edge", 32'(rise_o & fall_o), 32'd0);
        if (rise_o) n_rise++;
        if (fall_o) n_fall++;
        if (busy_o) n_busy++;
    endtask

    task automatic steps(input logic val, input int n);
        serial_i = val;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_tallies();
        n_rise = 0;
        n_fall = 0;
        n_busy = 0;
    endtask

    initial begin
        rstn_i      = 1'b0;
        en_i        = 1'b1;
        serial_i    = 1'b0;
        threshold_i = CW'(4);
        clr_i       = 1'b0;
        model_reset();
        clear_tallies();

        // Reset values
        #1;
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_rise", 32'(rise_o), 32'd0);
        check("rst_fall", 32'(fall_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_glitch", 32'(glitch_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        steps(1'b0, 2);

        // Clean rise with threshold 4
        clear_tallies();
        steps(1'b1, 3);
        check("rise_before_4th_edge", 32'(level_o), 32'd0);
        step();
        check("rise_at_4th_edge", 32'(level_o), 32'd1);
        steps(1'b1, 6);
        check("rise_busy_cycles", 32'(n_busy), 32'd3);
        check("rise_pulse_count", 32'(n_rise), 32'd1);
        check("rise_no_fall", 32'(n_fall), 32'd0);

        // Return low
        clear_tallies();
        steps(1'b0, 6);
        check("fall_level", 32'(level_o), 32'd0);
        check("fall_pulse_count", 32'(n_fall), 32'd1);

        // Three short pulses rejected
        clear_tallies();
        for (int g = 0; g < 3; g++) begin
            steps(1'b1, 3);
            steps(1'b0, 3);
        end
        check("glitch_level", 32'(level_o), 32'd0);
        check("glitch_no_rise", 32'(n_rise), 32'd0);
        check("glitch_count3", 32'(glitch_cnt_o), 32'd3);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("glitch_cleared", 32'(glitch_cnt_o), 32'd0);

        // Threshold 0 and 1: follow the input one edge later
        for (int t = 0; t < 2; t++) begin
            threshold_i = CW'(t);
            clear_tallies();
            for (int i = 0; i < 8; i++) begin
                serial_i = ~serial_i;
                step();
                check("follow_level", 32'(level_o), 32'(serial_i));
            end
            check("follow_rises", 32'(n_rise), 32'd4);
            check("follow_falls", 32'(n_fall), 32'd4);
            check("follow_glitch", 32'(glitch_cnt_o), 32'd0);
        end
        steps(1'b0, 2);

        // Saturation at 3, then clear beating a simultaneous increment
        threshold_i = CW'(4);
        for (int g = 0; g < 5; g++) begin
            steps(1'b1, 2);
            steps(1'b0, 2);
        end
        check("glitch_saturated", 32'(glitch_cnt_o), 32'd3);
        steps(1'b1, 2);
        serial_i = 1'b0;
        clr_i    = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr_beats_incr", 32'(glitch_cnt_o), 32'd0);
        steps(1'b0, 2);

        // Disable mid-qualification with threshold 8
        threshold_i = CW'(8);
        steps(1'b1, 5);
        check("pre_disable_busy", 32'(busy_o), 32'd1);
        en_i = 1'b0;
        step();
        check("disable_busy", 32'(busy_o), 32'd0);
        check("disable_level", 32'(level_o), 32'd0);
        check("disable_glitch", 32'(glitch_cnt_o), 32'd0);
        en_i = 1'b1;
        steps(1'b0, 2);

        // Async reset mid-qualification
        steps(1'b1, 5);
        rstn_i = 1'b0;
        #1;
        model_reset();
        check("midrst_level", 32'(level_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_rise", 32'(rise_o), 32'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        clear_tallies();
        steps(1'b0, 2);
        check("midrst_no_rise", 32'(n_rise), 32'd0);

        // Threshold lowered below the running count
        steps(1'b1, 5);
        check("lower_pre_level", 32'(level_o), 32'd0);
        threshold_i = CW'(3);
        step();
        check("lower_level", 32'(level_o), 32'd1);
        check("lower_rise", 32'(rise_o), 32'd1);
        steps(1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
